// File: rtl/sseg_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : sseg_scan_capture
// Brief    : Recovers per-digit hex nibbles from a multiplexed 7-seg bus.
// Revision : 1.0 - initial release
// ============================================================================
module sseg_scan_capture #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:6]  SSeg,
  input  logic [3:0]  An,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        frame_valid,
  output logic        seg_error,
  output logic [1:0]  err_digit
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_SETTLE  = 2'd1;
  localparam logic [1:0] c_CAPTURE = 2'd2;
  localparam logic [1:0] c_HOLD    = 2'd3;
  localparam logic [7:0] c_SETTLE_CNT = 8'(SETTLE_CYCLES);

  logic [6:0] r_segSamp;   // bit 6 = segment a
  logic [3:0] r_anSamp;
  logic [1:0] r_state;
  logic [7:0] r_count;
  logic [3:0] r_anLatch;
  logic [1:0] r_digitIdx;

  logic [1:0] w_stateNext;
  logic [7:0] w_countNext;
  logic [7:0] w_countInc;
  logic [3:0] w_latchNext;
  logic [1:0] w_idxNext;
  logic       w_startScan;
  logic       w_goIdle;
  logic       w_anSingle;
  logic [1:0] w_anIdx;
  logic       w_changed;
  logic [6:0] w_segHi;
  logic [3:0] w_nibble;
  logic       w_segOk;
  logic       w_capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_segSamp <= 7'h7F;
      r_anSamp  <= 4'hF;
    end else begin
      r_segSamp <= SSeg;
      r_anSamp  <= An;
    end
  end

  always_comb begin
    w_anSingle = 1'b1;
    w_anIdx    = 2'd0;
    case (r_anSamp)
      4'b1110: w_anIdx = 2'd0;
      4'b1101: w_anIdx = 2'd1;
      4'b1011: w_anIdx = 2'd2;
      4'b0111: w_anIdx = 2'd3;
      default: w_anSingle = 1'b0;
    endcase
  end

  assign w_changed  = (r_anSamp != r_anLatch);
  assign w_countInc = (r_count == 8'hFF) ? r_count : r_count + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_IDLE;
      r_count    <= 8'd0;
      r_anLatch  <= 4'hF;
      r_digitIdx <= 2'd0;
    end else begin
      r_state    <= w_stateNext;
      r_count    <= w_countNext;
      r_anLatch  <= w_latchNext;
      r_digitIdx <= w_idxNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    w_latchNext = r_anLatch;
    w_idxNext   = r_digitIdx;
    w_startScan = 1'b0;
    w_goIdle    = 1'b0;
    case (r_state)
      c_IDLE: begin
        w_countNext = 8'd0;
        w_startScan = w_anSingle;
      end
      c_SETTLE: begin
        if (w_changed) begin
          w_startScan = w_anSingle;
          w_goIdle    = !w_anSingle;
        end else begin
          w_countNext = w_countInc;
          if (w_countInc >= c_SETTLE_CNT) w_stateNext = c_CAPTURE;
        end
      end
      c_CAPTURE: w_stateNext = c_HOLD;
      c_HOLD: begin
        if (w_changed) begin
          w_startScan = w_anSingle;
          w_goIdle    = !w_anSingle;
        end
      end
      default: w_goIdle = 1'b1;
    endcase
    // A new slot counts its first registered cycle immediately.
    if (w_startScan) begin
      w_stateNext = (c_SETTLE_CNT <= 8'd1) ? c_CAPTURE : c_SETTLE;
      w_countNext = 8'd1;
      w_latchNext = r_anSamp;
      w_idxNext   = w_anIdx;
    end
    if (w_goIdle) begin
      w_stateNext = c_IDLE;
      w_countNext = 8'd0;
      w_latchNext = r_anSamp;
    end
  end

  assign w_segHi = ~r_segSamp;

  always_comb begin
    w_capture = (r_state == c_CAPTURE);
    w_segOk   = 1'b1;
    w_nibble  = 4'h0;
    case (w_segHi)
      7'b1111110: w_nibble = 4'h0;
      7'b0110000: w_nibble = 4'h1;
      7'b1101101: w_nibble = 4'h2;
      7'b1111001: w_nibble = 4'h3;
      7'b0110011: w_nibble = 4'h4;
      7'b1011011: w_nibble = 4'h5;
      7'b1011111: w_nibble = 4'h6;
      7'b1110000: w_nibble = 4'h7;
      7'b1111111: w_nibble = 4'h8;
      7'b1111011: w_nibble = 4'h9;
      7'b1110111: w_nibble = 4'hA;
      7'b0011111: w_nibble = 4'hB;
      7'b1001110: w_nibble = 4'hC;
      7'b0111101: w_nibble = 4'hD;
      7'b1001111: w_nibble = 4'hE;
      7'b1000111: w_nibble = 4'hF;
      default:    w_segOk  = 1'b0;
    endcase
  end

  // A full valid set and a capture never share an edge: capture is followed by HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits      <= 16'h0000;
      digit_valid <= 4'b0000;
      frame_valid <= 1'b0;
      seg_error   <= 1'b0;
      err_digit   <= 2'd0;
    end else begin
      frame_valid <= 1'b0;
      seg_error   <= 1'b0;
      if (digit_valid == 4'b1111) begin
        digit_valid <= 4'b0000;
        frame_valid <= 1'b1;
      end
      if (w_capture) begin
        if (w_segOk) begin
          digits[{r_digitIdx, 2'b00} +: 4] <= w_nibble;
          digit_valid[r_digitIdx]          <= 1'b1;
        end else begin
          seg_error <= 1'b1;
          err_digit <= r_digitIdx;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_sseg_scan_capture
// Brief    : Self-checking bench with a cycle model of the scan monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_capture;

  localparam int SETTLE = 4;
  localparam logic [6:0] DEC_TAB [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  logic        clk = 1'b0;
  logic        rst;
  logic [0:6]  SSeg;
  logic [3:0]  An;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        seg_error;
  logic [1:0]  err_digit;

  int vectors = 0;
  int miscompares = 0;
  int frameCnt = 0;
  int errCnt = 0;
  bit checkEn = 1'b0;

  sseg_scan_capture #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst), .SSeg(SSeg), .An(An),
    .digits(digits), .digit_valid(digit_valid), .frame_valid(frame_valid),
    .seg_error(seg_error), .err_digit(err_digit)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (DEC_TAB[i] == p) return i;
    return -1;
  endfunction

  function automatic int singleIdx(input logic [3:0] a);
    if ($countones(~a) != 1) return -1;
    for (int i = 0; i < 4; i++) if (!a[i]) return i;
    return -1;
  endfunction

  // Reference model: the slot being watched, how long it has been seen, and
  // whether it was already captured.
  logic [3:0]  mAnQ = 4'hF;
  logic [6:0]  mSegQ = 7'h7F;
  bit          watching = 1'b0, holding = 1'b0, capPend = 1'b0;
  logic [3:0]  watchPat = 4'hF;
  int          age = 0, capK = 0, mWrites = 0;
  logic [15:0] mDigits = 16'h0;
  logic [3:0]  mDv = 4'h0;
  logic        mFrame = 1'b0, mErr = 1'b0;
  logic [1:0]  mErrDig = 2'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mAnQ = 4'hF; mSegQ = 7'h7F; watching = 0; holding = 0; capPend = 0;
      watchPat = 4'hF; age = 0; capK = 0; mWrites = 0;
      mDigits = 16'h0; mDv = 4'h0; mFrame = 0; mErr = 0; mErrDig = 2'd0;
    end else begin
      int v;
      mFrame = 0;
      mErr = 0;
      if (mDv == 4'hF) begin
        mDv = 4'h0;
        mFrame = 1;
      end
      if (capPend) begin
        capPend = 0;
        holding = 1;
        v = decode(~mSegQ);
        if (v >= 0) begin
          mDigits[capK*4 +: 4] = 4'(v);
          mDv[capK] = 1'b1;
          mWrites++;
        end else begin
          mErr = 1;
          mErrDig = 2'(capK);
        end
      end else if (watching && mAnQ == watchPat) begin
        if (!holding) begin
          age++;
          if (age >= SETTLE) capPend = 1;
        end
      end else if (singleIdx(mAnQ) >= 0) begin
        watching = 1; holding = 0; watchPat = mAnQ;
        capK = singleIdx(mAnQ); age = 1;
        if (age >= SETTLE) capPend = 1;
      end else begin
        watching = 0;
      end
      mAnQ = An;
      mSegQ = SSeg;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      cmp("digits", 32'(digits), 32'(mDigits));
      cmp("digit_valid", 32'(digit_valid), 32'(mDv));
      cmp("frame_valid", 32'(frame_valid), 32'(mFrame));
      cmp("seg_error", 32'(seg_error), 32'(mErr));
      cmp("err_digit", 32'(err_digit), 32'(mErrDig));
      frameCnt += int'(frame_valid);
      errCnt += int'(seg_error);
    end
  end

  task automatic drive(input logic [3:0] a, input logic [6:0] segHi, input int n);
    An = a;
    SSeg = ~segHi;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    cmp("rst_digits", 32'(digits), 32'h0);
    cmp("rst_valid", 32'(digit_valid), 32'h0);
    cmp("rst_frame", 32'(frame_valid), 32'h0);
    cmp("rst_err", 32'({seg_error, err_digit}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    An = 4'hF;
    SSeg = 7'h7F;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkEn = 1'b1;

    // Reset in the middle of a scan, digit 0 = '1' held across it
    drive(4'b1110, DEC_TAB[1], 3);
    pulseReset();
    repeat (SETTLE + 1) @(negedge clk);
    cmp("post_rst_nocap", 32'(digit_valid), 32'h0);
    @(negedge clk);
    cmp("post_rst_cap_valid", 32'(digit_valid), 32'h1);
    cmp("post_rst_cap_digits", 32'(digits), 32'h0001);

    // Single digit with exact write latency
    pulseReset();
    An = 4'b1101;
    SSeg = ~7'b1111001;
    repeat (SETTLE + 1) @(negedge clk);
    cmp("single_early", 32'(digit_valid), 32'h0);
    @(negedge clk);
    cmp("single_valid", 32'(digit_valid), 32'b0010);
    cmp("single_nibble", 32'(digits[7:4]), 32'h3);
    repeat (10 - SETTLE - 2) @(negedge clk);
    cmp("single_writes", 32'(mWrites), 32'd1);
    drive(4'hF, 7'h00, 2);

    // Full frame A,b,1,6
    frameCnt = 0;
    drive(4'b1110, 7'b1110111, 8);
    drive(4'b1101, 7'b0011111, 8);
    drive(4'b1011, 7'b0110000, 8);
    drive(4'b0111, 7'b1011111, 8);
    drive(4'hF, 7'h00, 2);
    cmp("frame_digits", 32'(digits), 32'h61BA);
    cmp("frame_valid_clear", 32'(digit_valid), 32'h0);
    cmp("frame_pulses", 32'(frameCnt), 32'd1);

    // Undecodable pattern on digit 3
    errCnt = 0;
    drive(4'b0111, 7'b1010101, 10);
    drive(4'hF, 7'h00, 2);
    cmp("bad_pulses", 32'(errCnt), 32'd1);
    cmp("bad_err_digit", 32'(err_digit), 32'd3);
    cmp("bad_digit_kept", 32'(digits[15:12]), 32'h6);

    // Glitches: short slot and double anode
    pulseReset();
    drive(4'b1110, DEC_TAB[7], SETTLE - 1);
    drive(4'hF, DEC_TAB[7], 3);
    drive(4'b1100, DEC_TAB[7], 20);
    drive(4'hF, 7'h00, 2);
    cmp("glitch_valid", 32'(digit_valid), 32'h0);
    cmp("glitch_digits", 32'(digits), 32'h0);

    // Overwrite of digit 2 before the frame completes
    pulseReset();
    drive(4'b1011, 7'b1011011, 8);
    drive(4'hF, 7'h00, 2);
    cmp("ovw_first", 32'(digits[11:8]), 32'h5);
    drive(4'b1011, 7'b1001110, 8);
    drive(4'hF, 7'h00, 2);
    cmp("ovw_nibble", 32'(digits[11:8]), 32'hC);
    cmp("ovw_valid", 32'(digit_valid), 32'b0100);

    // Random scan traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] a;
      logic [6:0] s;
      int sel;
      sel = int'($urandom_range(0, 5));
      if (sel < 4) a = ~(4'b0001 << sel);
      else if (sel == 4) a = 4'hF;
      else a = 4'($urandom);
      if ($urandom_range(0, 3) != 0) s = DEC_TAB[$urandom_range(0, 15)];
      else s = 7'($urandom);
      drive(a, s, int'($urandom_range(1, 9)));
      if (i == 200) pulseReset();
    end
    drive(4'hF, 7'h00, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
